// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The prefetch entry carries the fetched word, its PC and the bus-error flag.
package rv_fetch_pkg;

  localparam int PKG_XLEN = 64;
  localparam int ILEN     = 32;

  localparam logic [ILEN-1:0]     RV_NOP  = 32'h0000_0013;
  localparam logic [PKG_XLEN-1:0] PC_STEP = 64'd4;

  typedef struct packed {
    logic [ILEN-1:0]     instr;
    logic [PKG_XLEN-1:0] pc;
    logic                err;
  } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of fetch entries with flush taking priority
// over push/pop. The head entry is visible combinationally.
module rv_fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty
);

  fetch_entry_t    mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            full_s;
  logic            do_push_s;
  logic            do_pop_s;

  // Occupancy flags and qualified push/pop strobes.
  always_comb begin
    full_s    = (count_r == CW'(DEPTH));
    empty     = (count_r == {CW{1'b0}});
    do_push_s = push && !full_s && !flush;
    do_pop_s  = pop && !empty && !flush;
    count     = count_r;
    head      = mem_r[rd_ptr_r];
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wr_entry;
  end

  rv_fetch_fifo_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push && !flush),
    .pop   (pop && !flush),
    .full  (full_s),
    .empty (empty)
  );

endmodule

// File: rtl/rv_fetch_fifo_chk.sv
// Protocol checks for the prefetch FIFO, kept apart from the datapath.
module rv_fetch_fifo_chk (
  input logic clk,
  input logic reset,
  input logic push,
  input logic pop,
  input logic full,
  input logic empty
);

  // The fetch credit scheme must never let a response land in a full buffer.
  assert property (@(posedge clk) disable iff (reset) !(push && full));
  assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/rv_fetch_unit.sv
// Instruction fetch front end: sequential PC generation, credit-limited req/gnt
// issue, in-order response buffering and redirect flush with in-flight drop.
module rv_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int              XLEN       = PKG_XLEN,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_err,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_err,
  input  logic            instr_ready
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CW + 1;
  localparam logic [XLEN-1:0] PC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] resp_pc_r;
  logic [CW-1:0]   outstanding_r;
  logic [CW-1:0]   drop_cnt_r;
  logic [CW-1:0]   fifo_count_s;
  logic            fifo_empty_s;
  fetch_entry_t    head_s;
  fetch_entry_t    wr_entry_s;
  logic            credit_s;
  logic            xfer_s;
  logic            drop_s;
  logic            push_s;
  logic            pop_s;
  logic [XLEN-1:0] redirect_base_s;

  // Credit, handshake and FIFO control; in-flight plus buffered never exceeds depth.
  always_comb begin
    credit_s        = ({1'b0, outstanding_r} + {1'b0, fifo_count_s}) < SUM_W'(FIFO_DEPTH);
    imem_req        = credit_s && !redirect_valid && !reset;
    imem_addr       = fetch_pc_r;
    xfer_s          = imem_req && imem_gnt;
    drop_s          = redirect_valid || (drop_cnt_r != {CW{1'b0}});
    push_s          = imem_rvalid && !drop_s;
    pop_s           = !fifo_empty_s && instr_ready && !redirect_valid;
    wr_entry_s      = '{instr: imem_rdata, pc: resp_pc_r, err: imem_err};
    redirect_base_s = redirect_pc & PC_MASK;
  end

  // Core-facing view of the FIFO head; NOP when nothing is buffered.
  always_comb begin
    instr_valid = !fifo_empty_s;
    if (fifo_empty_s) begin
      instr     = RV_NOP;
      instr_pc  = {XLEN{1'b0}};
      instr_err = 1'b0;
    end else begin
      instr     = head_s.instr;
      instr_pc  = head_s.pc;
      instr_err = head_s.err;
    end
  end

  // PC and request accounting; a redirect retires every old in-flight response as a drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      drop_cnt_r    <= {CW{1'b0}};
    end else begin
      outstanding_r <= outstanding_r + CW'(xfer_s) - CW'(imem_rvalid);
      if (redirect_valid) begin
        fetch_pc_r <= redirect_base_s;
        resp_pc_r  <= redirect_base_s;
        drop_cnt_r <= outstanding_r - CW'(imem_rvalid);
      end else begin
        if (xfer_s) fetch_pc_r <= fetch_pc_r + PC_STEP;
        if (push_s) resp_pc_r <= resp_pc_r + PC_STEP;
        if (imem_rvalid && (drop_cnt_r != {CW{1'b0}})) drop_cnt_r <= drop_cnt_r - CW'(1);
      end
    end
  end

  rv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (push_s),
    .pop      (pop_s),
    .wr_entry (wr_entry_s),
    .head     (head_s),
    .count    (fifo_count_s),
    .empty    (fifo_empty_s)
  );

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Scoreboard bench for rv_fetch_unit: a behavioural memory answers requests in order,
// the reference model predicts the instruction stream from the last reset/redirect PC.
module tb_rv_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_err;
  logic        instr_ready;

  rv_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .imem_err       (imem_err),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_err      (instr_err),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; logic [31:0] word; logic err; } exp_t;
  typedef struct { logic [63:0] addr; int due; } pend_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  logic [63:0] exp_tail_pc;
  int n_cmp = 0, n_bad = 0, pop_cnt = 0;
  int cyc = 0, grant_cnt = 0, gnt_limit = 1000000, lat_min = 1, lat_max = 1;
  bit mem_hold = 1'b0, gnt_rand = 1'b0, rv_rand = 1'b0;

  // Memory contents and fault map as pure functions of the address.
  function automatic logic [31:0] mem_word(logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  function automatic logic mem_err(logic [63:0] a);
    return (a[7:2] == 6'd2) || (a[7:2] == 6'd37);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic sb_push_next();
    exp_q.push_back('{exp_tail_pc, mem_word(exp_tail_pc), mem_err(exp_tail_pc)});
    exp_tail_pc = exp_tail_pc + 64'd4;
  endtask

  // A new stream starts at the word-aligned PC and increments by 4 with wrap.
  task automatic sb_restart(logic [63:0] pc);
    exp_q.delete();
    exp_tail_pc = pc & ~64'h3;
    repeat (8) sb_push_next();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: in-order responses after a per-request latency.
  initial begin : memory
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_err = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) pend_q.delete();
      else if (imem_req && imem_gnt) begin
        pend_q.push_back('{imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
        grant_cnt++;
      end
      @(posedge clk);
      cyc++;
      #2;
      imem_gnt = (grant_cnt < gnt_limit) && (!gnt_rand || ($urandom_range(3, 0) != 0));
      if (!reset && !mem_hold && pend_q.size() > 0 && pend_q[0].due <= cyc &&
          (!rv_rand || ($urandom_range(3, 0) != 0))) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_q[0].addr);
        imem_err    = mem_err(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        imem_err    = 1'($urandom_range(1, 0));
      end
    end
  end

  // Monitor: every accepted instruction must match the head of the expected stream.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && !redirect_valid) begin
        if (instr_valid && instr_ready) begin
          if (exp_q.size() == 0) sb_push_next();
          e = exp_q.pop_front();
          sb_push_next();
          pop_cnt++;
          check("instr_pc", instr_pc, e.pc);
          check("instr", {32'h0, instr}, {32'h0, e.word});
          check("instr_err", {63'h0, instr_err}, {63'h0, e.err});
        end else if (!instr_valid) begin
          check("idle_nop", {32'h0, instr}, 64'h13);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int p0;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0; instr_ready = 1'b0;
    sb_restart(64'h0);
    repeat (2) @(negedge clk);
    check("rst_req", {63'h0, imem_req}, 64'h0);
    check("rst_valid", {63'h0, instr_valid}, 64'h0);
    check("rst_instr", {32'h0, instr}, 64'h13);
    check("rst_pc", instr_pc, 64'h0);
    check("rst_err", {63'h0, instr_err}, 64'h0);

    // Streaming with 1-cycle memory; pc 0x8 carries a bus error.
    instr_ready = 1'b1;
    tick(); sb_restart(64'h0); reset = 1'b0;
    @(negedge clk);
    check("t1_req_c0", {63'h0, imem_req}, 64'h1);
    check("t1_addr_c0", imem_addr, 64'h0);
    check("t1_valid_c0", {63'h0, instr_valid}, 64'h0);
    @(negedge clk);
    check("t1_valid_c1", {63'h0, instr_valid}, 64'h0);
    repeat (20) begin
      @(negedge clk);
      check("t1_stream_valid", {63'h0, instr_valid}, 64'h1);
    end

    // Backpressure: credit stops issue after FIFO_DEPTH grants.
    tick(); reset = 1'b1; instr_ready = 1'b0;
    tick(); tick(); grant_cnt = 0; sb_restart(64'h0); reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("t2_grants", 64'(grant_cnt), 64'd4);
    check("t2_req_off", {63'h0, imem_req}, 64'h0);
    p0 = pop_cnt;
    tick(); instr_ready = 1'b1;
    repeat (12) @(negedge clk);
    check("t2_drained", 64'(pop_cnt - p0 >= 8), 64'h1);

    // Redirect with three requests still in flight.
    tick(); reset = 1'b1; mem_hold = 1'b1; gnt_limit = 3;
    tick(); tick(); grant_cnt = 0; sb_restart(64'h0); reset = 1'b0;
    for (int i = 0; i < 20 && grant_cnt < 3; i++) begin
      @(negedge clk); #1;
    end
    check("t3_inflight", 64'(grant_cnt), 64'd3);
    tick(); redirect_valid = 1'b1; redirect_pc = 64'h103; sb_restart(64'h100); gnt_limit = 1000000;
    @(negedge clk);
    check("t3_req_T", {63'h0, imem_req}, 64'h0);
    tick(); redirect_valid = 1'b0; mem_hold = 1'b0;
    @(negedge clk);
    check("t3_req_T1", {63'h0, imem_req}, 64'h1);
    check("t3_addr_T1", imem_addr, 64'h100);
    check("t3_valid_T1", {63'h0, instr_valid}, 64'h0);
    p0 = pop_cnt;
    repeat (15) @(negedge clk);
    check("t3_progress", 64'(pop_cnt - p0 >= 8), 64'h1);

    // Redirect coinciding with a response and a pop (2-cycle memory).
    lat_min = 2; lat_max = 2;
    repeat (12) tick();
    redirect_valid = 1'b1; redirect_pc = 64'h2000; sb_restart(64'h2000);
    @(negedge clk);
    check("t4_valid_T", {63'h0, instr_valid}, 64'h1);
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    check("t4_valid_T1", {63'h0, instr_valid}, 64'h0);
    repeat (15) @(negedge clk);

    // Asynchronous reset in the middle of a cycle.
    lat_min = 1; lat_max = 1;
    @(posedge clk); #3; reset = 1'b1; #1;
    check("t6_req", {63'h0, imem_req}, 64'h0);
    check("t6_valid", {63'h0, instr_valid}, 64'h0);
    check("t6_instr", {32'h0, instr}, 64'h13);
    check("t6_pc", instr_pc, 64'h0);
    check("t6_err", {63'h0, instr_err}, 64'h0);
    tick(); tick(); sb_restart(64'h0); reset = 1'b0;
    @(negedge clk);
    check("t6_addr", imem_addr, 64'h0);
    check("t6_req_after", {63'h0, imem_req}, 64'h1);
    repeat (10) @(negedge clk);

    // Randomized traffic with redirects, including PC wrap-around.
    lat_max = 3; gnt_rand = 1'b1; rv_rand = 1'b1;
    p0 = pop_cnt;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (redirect_valid) redirect_valid = 1'b0;
      else if ($urandom_range(29, 0) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = ($urandom_range(3, 0) == 0) ? 64'hFFFF_FFFF_FFFF_FFE6 : {$urandom, $urandom};
        sb_restart(redirect_pc);
      end
      instr_ready = ($urandom_range(9, 0) < 7);
    end
    tick(); redirect_valid = 1'b0; gnt_rand = 1'b0; rv_rand = 1'b0; instr_ready = 1'b1;
    repeat (30) tick();
    check("random_progress", 64'(pop_cnt - p0 >= 200), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
